// File: rtl/goertzel_multibin_engine.sv
// rtl/goertzel_multibin_engine.sv - multi-bin Goertzel power engine with ping-pong sample buffer
//
// Offset-binary ADC samples are written into one bank of a two-bank buffer.
// Each completed bank starts a sweep over NUM_BINS bins. For each bin the sweep
// fetches a 2*cos(w) coefficient, runs the Goertzel recursion, and emits a
// saturated power value tagged with its bin index.
//
// Ports:
//   sys_clk, sys_rst_n            clock (rising edge), asynchronous active-low reset
//   adc_valid, adc_data           sample strobe and offset-binary sample
//   coef_req, coef_bin            coefficient request pulse; bin index held until coef_valid
//   coef_valid, coef_data         coefficient return, signed Q2.14 value of 2*cos(w_k)
//   mag_valid, mag_data, mag_bin  power result pulse, saturated power, bin index
//   frame_done                    pulse together with the last bin's mag_valid
//   busy                          high from sweep start through the frame_done cycle
//   overrun_cnt                   saturating count of frames dropped while busy

module goertzel_multibin_engine #(
   parameter int D_W         = 8,
   parameter int NUM_SAMPLES = 512,
   parameter int NS_BITS     = 9,
   parameter int NUM_BINS    = 4,
   parameter int BIN_BITS    = 2,
   parameter int ACC_W       = 24,
   parameter int MAG_W       = 16,
   parameter int MAG_SHIFT   = 8
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                adc_valid,
   input  logic [D_W-1:0]      adc_data,
   output logic                coef_req,
   output logic [BIN_BITS-1:0] coef_bin,
   input  logic                coef_valid,
   input  logic [15:0]         coef_data,
   output logic                mag_valid,
   output logic [MAG_W-1:0]    mag_data,
   output logic [BIN_BITS-1:0] mag_bin,
   output logic                frame_done,
   output logic                busy,
   output logic [7:0]          overrun_cnt
);

   // c*s1 needs ACC_W+16 bits; after >>>14 it spans ACC_W+2 bits, so the
   // recursion sum x + (c*s1>>>14) - s2 fits comfortably in ACC_W+4 bits.
   localparam int PROD_W = ACC_W + 16;
   localparam int SUM_W  = ACC_W + 4;
   localparam int M_W    = ACC_W + 2;
   localparam int Q_W    = 2 * ACC_W + 2;

   localparam logic [NS_BITS-1:0]      LAST_ADDR = NS_BITS'(NUM_SAMPLES - 1);
   localparam logic [BIN_BITS-1:0]     LAST_BIN  = BIN_BITS'(NUM_BINS - 1);
   localparam logic signed [SUM_W-1:0] ACC_MAX   = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] ACC_MIN   = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RD,
      S_MAC,
      S_P1,
      S_P2,
      S_P3
   } state_t;

   state_t                  state_q, state_d;
   logic                    wr_bank_q, wr_bank_d;
   logic                    rd_bank_q, rd_bank_d;
   logic [NS_BITS-1:0]      wr_addr_q, wr_addr_d;
   logic [NS_BITS-1:0]      rd_addr_q, rd_addr_d;
   logic [BIN_BITS-1:0]     bin_q, bin_d;
   logic [7:0]              overrun_q, overrun_d;
   logic signed [15:0]      coef_q, coef_d;
   logic signed [ACC_W-1:0] s1_q, s1_d;
   logic signed [ACC_W-1:0] s2_q, s2_d;
   logic signed [M_W-1:0]   m_q, m_d;
   logic signed [Q_W-1:0]   q_q, q_d;

   logic [D_W-1:0]          mem [2*NUM_SAMPLES];
   logic [D_W-1:0]          bram_rd_data;

   logic                    frame_last;
   logic                    swap;
   logic signed [D_W-1:0]   x_s;
   logic signed [PROD_W-1:0] cs1_sh;
   logic signed [SUM_W-1:0] s_sum;
   logic signed [ACC_W-1:0] s_sat;
   logic signed [Q_W-1:0]   q_calc;
   logic signed [Q_W-1:0]   q_sh;
   logic [MAG_W-1:0]        mag_sat;

   assign busy        = (state_q != S_IDLE);
   assign coef_bin    = bin_q;
   assign overrun_cnt = overrun_q;

   // Writer and sweep use separate ports; they always address different banks
   // while a sweep is running, so no read/write collision handling is needed.
   always_ff @(posedge sys_clk) begin
      if (adc_valid) begin
         mem[{wr_bank_q, wr_addr_q}] <= adc_data;
      end
      bram_rd_data <= mem[{rd_bank_q, rd_addr_q}];
   end

   // Shared datapath: the c*s1 product serves both the recursion and P1.
   always_comb begin
      x_s    = {~bram_rd_data[D_W-1], bram_rd_data[D_W-2:0]};
      cs1_sh = (PROD_W'(coef_q) * PROD_W'(s1_q)) >>> 14;
      s_sum  = SUM_W'(x_s) + SUM_W'(cs1_sh) - SUM_W'(s2_q);
      if (s_sum > ACC_MAX) begin
         s_sat = ACC_MAX[ACC_W-1:0];
      end else if (s_sum < ACC_MIN) begin
         s_sat = ACC_MIN[ACC_W-1:0];
      end else begin
         s_sat = s_sum[ACC_W-1:0];
      end
      q_calc = Q_W'(s1_q) * Q_W'(s1_q) + Q_W'(s2_q) * Q_W'(s2_q) - Q_W'(m_q) * Q_W'(s2_q);
      q_sh   = q_q >>> MAG_SHIFT;
      // Rounding can make q slightly negative; clamp that to zero.
      if (q_sh[Q_W-1]) begin
         mag_sat = '0;
      end else if (|q_sh[Q_W-2:MAG_W]) begin
         mag_sat = '1;
      end else begin
         mag_sat = q_sh[MAG_W-1:0];
      end
   end

   // Writer: a frame completing while a sweep runs (including its final P3
   // cycle) is dropped and the same bank is overwritten by the next frame.
   always_comb begin
      frame_last = adc_valid && (wr_addr_q == LAST_ADDR);
      swap       = frame_last && !busy;
      wr_addr_d  = wr_addr_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      overrun_d  = overrun_q;
      if (adc_valid) begin
         wr_addr_d = wr_addr_q + NS_BITS'(1);
      end
      if (swap) begin
         wr_bank_d = ~wr_bank_q;
         rd_bank_d = wr_bank_q;
      end else if (frame_last && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end
   end

   // Sweep FSM
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      coef_d     = coef_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      rd_addr_d  = rd_addr_q;
      m_d        = m_q;
      q_d        = q_q;
      coef_req   = 1'b0;
      mag_valid  = 1'b0;
      mag_data   = '0;
      mag_bin    = '0;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (swap) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            coef_req = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (coef_valid) begin
               coef_d    = $signed(coef_data);
               s1_d      = '0;
               s2_d      = '0;
               rd_addr_d = '0;
               state_d   = S_RD;
            end
         end
         S_RD: begin
            state_d = S_MAC;
         end
         S_MAC: begin
            s1_d = s_sat;
            s2_d = s1_q;
            if (rd_addr_q == LAST_ADDR) begin
               state_d = S_P1;
            end else begin
               rd_addr_d = rd_addr_q + NS_BITS'(1);
               state_d   = S_RD;
            end
         end
         S_P1: begin
            m_d     = M_W'(cs1_sh);
            state_d = S_P2;
         end
         S_P2: begin
            q_d     = q_calc;
            state_d = S_P3;
         end
         S_P3: begin
            mag_valid = 1'b1;
            mag_data  = mag_sat;
            mag_bin   = bin_q;
            if (bin_q == LAST_BIN) begin
               frame_done = 1'b1;
               bin_d      = '0;
               state_d    = S_IDLE;
            end else begin
               bin_d   = bin_q + BIN_BITS'(1);
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= S_IDLE;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b1;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         bin_q     <= '0;
         overrun_q <= '0;
         coef_q    <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         m_q       <= '0;
         q_q       <= '0;
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         bin_q     <= bin_d;
         overrun_q <= overrun_d;
         coef_q    <= coef_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         m_q       <= m_d;
         q_q       <= q_d;
      end
   end

endmodule
